// File: rtl/hazard_stall_ctrl.sv
// Stall/flush control for the 5-stage pipeline: Tuse/Tnew RAW hazards plus a HI/LO busy counter.
// Hazard outputs are combinational and the mult/div state is registered. Optional perf counters are enabled by PERF_STALL_CNT_EN.
module hazard_stall_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] D_rs_addr,
    input  logic [4:0] D_rt_addr,
    input  logic [1:0] D_rs_tuse,
    input  logic [1:0] D_rt_tuse,
    input  logic       D_is_md,
    input  logic [4:0] E_write_addr,
    input  logic [1:0] E_tnew,
    input  logic [4:0] M_write_addr,
    input  logic [1:0] M_tnew,
    input  logic       E_md_start,
    input  logic       E_md_op,
    output logic       stall,
    output logic       PC_en,
    output logic       FD_en,
    output logic       DE_clear,
    output logic       EM_en,
    output logic       EM_clear,
    output logic       MW_en,
    output logic       md_busy,
    output logic       md_done
`ifdef PERF_STALL_CNT_EN
    ,
    output logic [31:0] stall_count,
    output logic [31:0] md_stall_count
`endif
);

    localparam logic [CNT_W-1:0] MULT_LD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD  = CNT_W'(DIV_CYCLES);

    logic             rs_hz_e;
    logic             rs_hz_m;
    logic             rt_hz_e;
    logic             rt_hz_m;
    logic             data_stall;
    logic             md_stall;
    logic [CNT_W-1:0] cnt;

    // A tuse of 3 can never be exceeded by a 2-bit tnew, so unused operands drop out naturally.
    always_comb begin
        rs_hz_e    = (D_rs_addr != 5'd0) && (D_rs_addr == E_write_addr) && (E_tnew > D_rs_tuse);
        rs_hz_m    = (D_rs_addr != 5'd0) && (D_rs_addr == M_write_addr) && (M_tnew > D_rs_tuse);
        rt_hz_e    = (D_rt_addr != 5'd0) && (D_rt_addr == E_write_addr) && (E_tnew > D_rt_tuse);
        rt_hz_m    = (D_rt_addr != 5'd0) && (D_rt_addr == M_write_addr) && (M_tnew > D_rt_tuse);
        data_stall = rs_hz_e || rs_hz_m || rt_hz_e || rt_hz_m;
        md_busy    = E_md_start || (cnt != '0);
        md_stall   = D_is_md && md_busy;
        stall      = data_stall || md_stall;
    end

    assign PC_en    = ~stall;
    assign FD_en    = ~stall;
    assign DE_clear = stall;
    assign EM_en    = 1'b1;
    assign EM_clear = 1'b0;
    assign MW_en    = 1'b1;

    // A new start reloads the counter even mid-operation and suppresses the completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt     <= '0;
            md_done <= 1'b0;
        end else begin
            if (E_md_start)
                cnt <= E_md_op ? DIV_LD : MULT_LD;
            else if (cnt != '0)
                cnt <= cnt - CNT_W'(1);
            md_done <= !E_md_start && (cnt == CNT_W'(1));
        end
    end

`ifdef PERF_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count    <= 32'd0;
            md_stall_count <= 32'd0;
        end else begin
            if (stall)
                stall_count <= stall_count + 32'd1;
            if (md_stall)
                md_stall_count <= md_stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl; perf-counter checks run only when PERF_STALL_CNT_EN is defined.
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] D_rs_addr, D_rt_addr, E_write_addr, M_write_addr;
    logic [1:0] D_rs_tuse, D_rt_tuse, E_tnew, M_tnew;
    logic       D_is_md, E_md_start, E_md_op;
    logic       stall, PC_en, FD_en, DE_clear, EM_en, EM_clear, MW_en, md_busy, md_done;
`ifdef PERF_STALL_CNT_EN
    logic [31:0] stall_count, md_stall_count;
`endif

    int total = 0;
    int bad   = 0;

    // {stall, PC_en, FD_en, DE_clear, EM_en, EM_clear, MW_en}
    localparam logic [6:0] STALLV = 7'b1001101;
    localparam logic [6:0] RUNV   = 7'b0110101;
    logic [6:0] ctrl;
    assign ctrl = {stall, PC_en, FD_en, DE_clear, EM_en, EM_clear, MW_en};

    hazard_stall_ctrl dut (
        .clk(clk), .reset(reset),
        .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
        .D_rs_tuse(D_rs_tuse), .D_rt_tuse(D_rt_tuse), .D_is_md(D_is_md),
        .E_write_addr(E_write_addr), .E_tnew(E_tnew),
        .M_write_addr(M_write_addr), .M_tnew(M_tnew),
        .E_md_start(E_md_start), .E_md_op(E_md_op),
        .stall(stall), .PC_en(PC_en), .FD_en(FD_en), .DE_clear(DE_clear),
        .EM_en(EM_en), .EM_clear(EM_clear), .MW_en(MW_en),
        .md_busy(md_busy), .md_done(md_done)
`ifdef PERF_STALL_CNT_EN
        , .stall_count(stall_count), .md_stall_count(md_stall_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        D_rs_addr = 5'd0; D_rt_addr = 5'd0; D_rs_tuse = 2'd3; D_rt_tuse = 2'd3;
        D_is_md = 1'b0; E_write_addr = 5'd0; E_tnew = 2'd0;
        M_write_addr = 5'd0; M_tnew = 2'd0; E_md_start = 1'b0; E_md_op = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        E_write_addr = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd1;
        #1;
        total++; if (ctrl !== STALLV) begin bad++; $display("FAIL reset_comb_stall got=%b exp=%b", ctrl, STALLV); end
        idle();
        step();
        reset = 1'b0;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL reset_ctrl got=%b exp=%b", ctrl, RUNV); end
        total++; if ({md_busy, md_done} !== 2'b00) begin bad++; $display("FAIL reset_md got=%b exp=00", {md_busy, md_done}); end
    endtask

    task automatic test_load_use();
        idle();
        E_write_addr = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd1;
        #1;
        total++; if (ctrl !== STALLV) begin bad++; $display("FAIL load_use_stall got=%b exp=%b", ctrl, STALLV); end
        step();
        E_tnew = 2'd1;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL load_use_release got=%b exp=%b", ctrl, RUNV); end
        idle();
        E_write_addr = 5'd17; E_tnew = 2'd2; D_rt_addr = 5'd17; D_rt_tuse = 2'd1;
        #1;
        total++; if (ctrl !== STALLV) begin bad++; $display("FAIL load_use_rt got=%b exp=%b", ctrl, STALLV); end
        D_rt_addr = 5'd18;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL addr_mismatch got=%b exp=%b", ctrl, RUNV); end
    endtask

    task automatic test_no_false_stall();
        idle();
        D_rs_addr = 5'd0; E_write_addr = 5'd0; E_tnew = 2'd2; D_rs_tuse = 2'd0;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL zero_addr got=%b exp=%b", ctrl, RUNV); end
        idle();
        D_rt_addr = 5'd9; E_write_addr = 5'd9; E_tnew = 2'd2; D_rt_tuse = 2'd3;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL tuse3 got=%b exp=%b", ctrl, RUNV); end
    endtask

    task automatic test_m_hazard();
        idle();
        M_write_addr = 5'd5; M_tnew = 2'd1; D_rt_addr = 5'd5; D_rt_tuse = 2'd0;
        #1;
        total++; if (ctrl !== STALLV) begin bad++; $display("FAIL m_hazard got=%b exp=%b", ctrl, STALLV); end
        M_tnew = 2'd0;
        #1;
        total++; if (ctrl !== RUNV) begin bad++; $display("FAIL m_release got=%b exp=%b", ctrl, RUNV); end
        idle();
        M_write_addr = 5'd3; M_tnew = 2'd2; D_rs_addr = 5'd3; D_rs_tuse = 2'd1;
        #1;
        total++; if (ctrl !== STALLV) begin bad++; $display("FAIL m_hazard_rs got=%b exp=%b", ctrl, STALLV); end
        idle();
    endtask

    // Mult start at c=0 with D_is_md held: busy/stall c=0..5, done pulse at c=6 only.
    task automatic test_mult();
        logic eb, ed;
        idle();
        D_is_md = 1'b1; E_md_start = 1'b1; E_md_op = 1'b0;
        for (int c = 0; c < 8; c++) begin
            #1;
            eb = (c <= 5); ed = (c == 6);
            total++;
            if ({md_busy, md_done, stall} !== {eb, ed, eb}) begin
                bad++; $display("FAIL mult_c%0d got busy/done/stall=%b exp=%b", c, {md_busy, md_done, stall}, {eb, ed, eb});
            end
            step();
            E_md_start = 1'b0;
        end
        idle();
    endtask

    // Div at c=0, mult reload at c=3 (cnt=5 at c=4). Without reset: busy to c=8, done at c=9.
    // With reset at c=5: busy drops at c=6 and done never pulses. D_is_md=0 so no stall.
    task automatic test_div_reload(input bit do_rst);
        logic eb, ed;
        idle();
        for (int c = 0; c < 11; c++) begin
            E_md_start = (c == 0) || (c == 3);
            E_md_op    = (c == 0);
            reset      = do_rst && (c == 5);
            #1;
            eb = do_rst ? (c <= 5) : (c <= 8);
            ed = !do_rst && (c == 9);
            total++;
            if ({md_busy, md_done, stall} !== {eb, ed, 1'b0}) begin
                bad++; $display("FAIL div_reload_rst%0d_c%0d got busy/done/stall=%b exp=%b", do_rst, c, {md_busy, md_done, stall}, {eb, ed, 1'b0});
            end
            step();
        end
        reset = 1'b0;
        idle();
    endtask

    // Restart on the last busy cycle (c=5) suppresses done; second op ends with done at c=11.
    task automatic test_back_to_back();
        logic eb, ed;
        idle();
        for (int c = 0; c < 13; c++) begin
            E_md_start = (c == 0) || (c == 5);
            E_md_op    = 1'b0;
            #1;
            eb = (c <= 10); ed = (c == 11);
            total++;
            if ({md_busy, md_done} !== {eb, ed}) begin
                bad++; $display("FAIL b2b_c%0d got busy/done=%b exp=%b", c, {md_busy, md_done}, {eb, ed});
            end
            step();
        end
        idle();
    endtask

`ifdef PERF_STALL_CNT_EN
    task automatic test_perf();
        idle();
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if ({stall_count, md_stall_count} !== 64'd0) begin bad++; $display("FAIL perf_reset got=%0d/%0d exp=0/0", stall_count, md_stall_count); end
        E_write_addr = 5'd8; E_tnew = 2'd2; D_rs_addr = 5'd8; D_rs_tuse = 2'd1;
        repeat (4) step();
        idle();
        D_is_md = 1'b1; E_md_start = 1'b1;
        step();
        E_md_start = 1'b0;
        repeat (2) step();
        idle();
        repeat (6) step();
        total++; if (stall_count !== 32'd7) begin bad++; $display("FAIL perf_stall_count got=%0d exp=7", stall_count); end
        total++; if (md_stall_count !== 32'd3) begin bad++; $display("FAIL perf_md_stall_count got=%0d exp=3", md_stall_count); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        total++; if ({stall_count, md_stall_count} !== 64'd0) begin bad++; $display("FAIL perf_rereset got=%0d/%0d exp=0/0", stall_count, md_stall_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_m_hazard();
        test_mult();
        test_div_reload(1'b0);
        test_div_reload(1'b1);
        test_back_to_back();
`ifdef PERF_STALL_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
